// File: rtl/kangaroo_video_pkg.sv
// kangaroo_video_pkg
// Shared raster timing defaults for the Kangaroo video path and the
// position type used by the counters. DEF_CW is the default width of
// each position counter; the DEF_H_* / DEF_V_* constants describe a
// 384 x 264 raster with a 256 x 240 visible window.
package kangaroo_video_pkg;

    localparam int DEF_CW           = 9;

    localparam int DEF_H_TOTAL      = 384;
    localparam int DEF_H_ACTIVE     = 256;
    localparam int DEF_H_SYNC_START = 296;
    localparam int DEF_H_SYNC_END   = 328;

    localparam int DEF_V_TOTAL      = 264;
    localparam int DEF_V_ACTIVE     = 240;
    localparam int DEF_V_SYNC_START = 244;
    localparam int DEF_V_SYNC_END   = 247;

    typedef logic [DEF_CW-1:0] pos_t;

endpackage

// File: rtl/video_sync_gen_if.sv
// video_sync_gen_if
// Raster timing bus between the sync generator and its consumers.
//   _CE      pixel advance enable (prescaler RCO), into the generator
//   _HCNT    horizontal position
//   _VCNT    vertical position
//   _HSYNC   horizontal sync, active-low
//   _VSYNC   vertical sync, active-low
//   _HBLANK  horizontal blanking
//   _VBLANK  vertical blanking
//   _FRAME   one-cycle frame-start strobe
//   _CSYNC   composite sync, active-low (only with VIDEO_SYNC_GEN_CSYNC_EN)
// master: the generator side. slave: the consumer/driver side.
interface video_sync_gen_if #(
    parameter int CW = kangaroo_video_pkg::DEF_CW
);
    logic          _CE;
    logic [CW-1:0] _HCNT;
    logic [CW-1:0] _VCNT;
    logic          _HSYNC;
    logic          _VSYNC;
    logic          _HBLANK;
    logic          _VBLANK;
    logic          _FRAME;
`ifdef VIDEO_SYNC_GEN_CSYNC_EN
    logic          _CSYNC;
`endif

    modport master (
        input  _CE,
        output _HCNT, _VCNT, _HSYNC, _VSYNC, _HBLANK, _VBLANK, _FRAME
`ifdef VIDEO_SYNC_GEN_CSYNC_EN
        , output _CSYNC
`endif
    );

    modport slave (
        output _CE,
        input  _HCNT, _VCNT, _HSYNC, _VSYNC, _HBLANK, _VBLANK, _FRAME
`ifdef VIDEO_SYNC_GEN_CSYNC_EN
        , input _CSYNC
`endif
    );

endinterface

// File: rtl/video_mod_counter.sv
// video_mod_counter
// Modulo-MOD up-counter with enable and terminal-count output.
//   _CLK   clock
//   _CLR   asynchronous active-high clear
//   _CE    count enable
//   count  current value, 0..MOD-1
//   _TC    high when enabled and count is at MOD-1 (the wrap edge)
module video_mod_counter #(
    parameter int W   = 9,
    parameter int MOD = 384
) (
    input  logic         _CLK,
    input  logic         _CLR,
    input  logic         _CE,
    output logic [W-1:0] count,
    output logic         _TC
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (_CE) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge _CLK or posedge _CLR) begin
        if (_CLR) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign _TC   = _CE && (count_q == LAST);

endmodule

// File: rtl/video_sync_gen.sv
// video_sync_gen
// Raster timing generator: cascaded horizontal/vertical position counters
// with registered sync, blanking and frame-start decode.
//   _CLK  system clock (rising edge)
//   _CLR  asynchronous active-high reset
//   vif   video_sync_gen_if.master: _CE in; _HCNT, _VCNT, _HSYNC, _VSYNC,
//         _HBLANK, _VBLANK, _FRAME (and _CSYNC) out
// Optional feature macro: VIDEO_SYNC_GEN_CSYNC_EN adds the registered
// active-low composite sync _CSYNC = _HSYNC & _VSYNC.
module video_sync_gen
    import kangaroo_video_pkg::*;
#(
    parameter int CW           = DEF_CW,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_END   = DEF_H_SYNC_END,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
    input  logic             _CLK,
    input  logic             _CLR,
    video_sync_gen_if.master vif
);

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
          H_SYNC_END <= H_TOTAL && H_TOTAL <= (1 << CW))) begin : g_bad_h
        $error("video_sync_gen: illegal horizontal timing parameters");
    end
    if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
          V_SYNC_END <= V_TOTAL && V_TOTAL <= (1 << CW))) begin : g_bad_v
        $error("video_sync_gen: illegal vertical timing parameters");
    end

    // Sync end compared as "<= END-1" so END = 2**CW still fits in CW bits.
    localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS  = CW'(H_SYNC_START);
    localparam logic [CW-1:0] H_SEL = CW'(H_SYNC_END - 1);
    localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS  = CW'(V_SYNC_START);
    localparam logic [CW-1:0] V_SEL = CW'(V_SYNC_END - 1);

    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] h_nxt, v_nxt;
    logic          h_tc, v_tc;

    video_mod_counter #(.W(CW), .MOD(H_TOTAL)) u_h_cnt (
        ._CLK (_CLK),
        ._CLR (_CLR),
        ._CE  (vif._CE),
        .count(h_cnt),
        ._TC  (h_tc)
    );

    video_mod_counter #(.W(CW), .MOD(V_TOTAL)) u_v_cnt (
        ._CLK (_CLK),
        ._CLR (_CLR),
        ._CE  (h_tc),
        .count(v_cnt),
        ._TC  (v_tc)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic hblank_q, hblank_d;
    logic vblank_q, vblank_d;
    logic frame_q, frame_d;

    // Decode the values the counters will hold after this edge, so the
    // registered decode lines up with the counts in the same cycle.
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (vif._CE) begin
            h_nxt = h_tc ? '0 : h_cnt + 1'b1;
        end
        if (h_tc) begin
            v_nxt = v_tc ? '0 : v_cnt + 1'b1;
        end
        hsync_d  = !((h_nxt >= H_SS) && (h_nxt <= H_SEL));
        vsync_d  = !((v_nxt >= V_SS) && (v_nxt <= V_SEL));
        hblank_d = (h_nxt >= H_ACT);
        vblank_d = (v_nxt >= V_ACT);
        // v_tc already implies _CE and the horizontal wrap.
        frame_d  = v_tc;
    end

    always_ff @(posedge _CLK or posedge _CLR) begin
        if (_CLR) begin
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            frame_q  <= frame_d;
        end
    end

`ifdef VIDEO_SYNC_GEN_CSYNC_EN
    logic csync_q, csync_d;

    always_comb begin
        csync_d = hsync_d & vsync_d;
    end

    always_ff @(posedge _CLK or posedge _CLR) begin
        if (_CLR) begin
            csync_q <= 1'b1;
        end else begin
            csync_q <= csync_d;
        end
    end

    assign vif._CSYNC = csync_q;
`endif

    assign vif._HCNT   = h_cnt;
    assign vif._VCNT   = v_cnt;
    assign vif._HSYNC  = hsync_q;
    assign vif._VSYNC  = vsync_q;
    assign vif._HBLANK = hblank_q;
    assign vif._VBLANK = vblank_q;
    assign vif._FRAME  = frame_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// tb_video_sync_gen
// Directed bench for video_sync_gen. Instance A uses the default raster
// for reset, hold, line sweep and mid-line reset; instance B uses a tiny
// 10 x 8 raster so whole frames (vertical decode, frame strobe) fit in a
// short run, driven from a table of hand-computed checkpoints.
module tb_video_sync_gen;
    import kangaroo_video_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    video_sync_gen_if #(.CW(DEF_CW)) vif_a ();
    video_sync_gen_if #(.CW(4))      vif_b ();

    video_sync_gen u_dut_a (
        ._CLK(clk),
        ._CLR(rst),
        .vif (vif_a)
    );

    video_sync_gen #(
        .CW(4),
        .H_TOTAL(10), .H_ACTIVE(4), .H_SYNC_START(6), .H_SYNC_END(8),
        .V_TOTAL(8),  .V_ACTIVE(5), .V_SYNC_START(6), .V_SYNC_END(7)
    ) u_dut_b (
        ._CLK(clk),
        ._CLR(rst),
        .vif (vif_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_hcnt"},   int'(vif_a._HCNT),   0);
        chk({tag, "_vcnt"},   int'(vif_a._VCNT),   0);
        chk({tag, "_hsync"},  int'(vif_a._HSYNC),  1);
        chk({tag, "_vsync"},  int'(vif_a._VSYNC),  1);
        chk({tag, "_hblank"}, int'(vif_a._HBLANK), 0);
        chk({tag, "_vblank"}, int'(vif_a._VBLANK), 0);
        chk({tag, "_frame"},  int'(vif_a._FRAME),  0);
`ifdef VIDEO_SYNC_GEN_CSYNC_EN
        chk({tag, "_csync"},  int'(vif_a._CSYNC),  1);
`endif
    endtask

    typedef struct {
        int adv;
        bit ce;
        int h;
        int v;
        bit hs;
        bit vs;
        bit hb;
        bit vb;
        bit fr;
        int nfr;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   mh, mv, first_hb, hs_low, guard, nfr;
        pos_t exp_h;

        //       adv ce  h  v hs vs hb vb fr nfr
        vecs[0]  = '{ 1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{ 3, 1, 4, 0, 1, 1, 1, 0, 0, 0};
        vecs[2]  = '{ 1, 0, 4, 0, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{ 2, 1, 6, 0, 0, 1, 1, 0, 0, 0};
        vecs[4]  = '{ 1, 1, 7, 0, 0, 1, 1, 0, 0, 0};
        vecs[5]  = '{ 1, 1, 8, 0, 1, 1, 1, 0, 0, 0};
        vecs[6]  = '{ 1, 1, 9, 0, 1, 1, 1, 0, 0, 0};
        vecs[7]  = '{ 1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
        vecs[8]  = '{40, 1, 0, 5, 1, 1, 0, 1, 0, 0};
        vecs[9]  = '{ 9, 1, 9, 5, 1, 1, 1, 1, 0, 0};
        vecs[10] = '{ 1, 1, 0, 6, 1, 0, 0, 1, 0, 0};
        vecs[11] = '{ 9, 1, 9, 6, 1, 0, 1, 1, 0, 0};
        vecs[12] = '{ 1, 1, 0, 7, 1, 1, 0, 1, 0, 0};
        vecs[13] = '{ 9, 1, 9, 7, 1, 1, 1, 1, 0, 0};
        vecs[14] = '{ 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        vecs[15] = '{ 1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[16] = '{79, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        vecs[17] = '{ 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};

        // Reset held with _CE high: reset wins on every edge.
        rst = 1'b1;
        vif_a._CE = 1'b1;
        vif_b._CE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a_reset($sformatf("rst%0d", i));
        end

        // Release half a cycle from the rising edge, then hold.
        @(negedge clk);
        rst = 1'b0;
        vif_a._CE = 1'b0;
        vif_b._CE = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("hold%0d_hcnt", i),  int'(vif_a._HCNT),  0);
            chk($sformatf("hold%0d_vcnt", i),  int'(vif_a._VCNT),  0);
            chk($sformatf("hold%0d_frame", i), int'(vif_a._FRAME), 0);
        end

        // One full line on the default raster.
        vif_a._CE = 1'b1;
        mh = 0;
        mv = 0;
        first_hb = -1;
        hs_low = 0;
        for (int i = 0; i < 384; i++) begin
            tick();
            mh = (mh == 383) ? 0 : mh + 1;
            if (mh == 0) mv = mv + 1;
            chk("line_hcnt",   int'(vif_a._HCNT),   mh);
            chk("line_vcnt",   int'(vif_a._VCNT),   mv);
            chk("line_hsync",  int'(vif_a._HSYNC),  (mh >= 296 && mh < 328) ? 0 : 1);
            chk("line_hblank", int'(vif_a._HBLANK), (mh >= 256) ? 1 : 0);
            chk("line_vsync",  int'(vif_a._VSYNC),  1);
            chk("line_vblank", int'(vif_a._VBLANK), 0);
            chk("line_frame",  int'(vif_a._FRAME),  0);
`ifdef VIDEO_SYNC_GEN_CSYNC_EN
            chk("line_csync",  int'(vif_a._CSYNC),  (mh >= 296 && mh < 328) ? 0 : 1);
`endif
            if (vif_a._HBLANK && first_hb < 0) first_hb = int'(vif_a._HCNT);
            if (!vif_a._HSYNC) hs_low++;
        end
        chk("first_hblank_hcnt", first_hb, 256);
        chk("hsync_low_cycles",  hs_low,   32);

        // Advance to (100, 50), then reset asynchronously mid-line.
        guard = 0;
        while (!(vif_a._HCNT == 9'd100 && vif_a._VCNT == 9'd50) && guard < 20000) begin
            tick();
            guard++;
        end
        chk("cycles_to_100_50", guard, 49 * 384 + 100);
        chk("pre_clr_vblank", int'(vif_a._VBLANK), 0);
        #2;
        rst = 1'b1;
        #1;
        chk_a_reset("async_clr");
        tick();
        chk_a_reset("clr_edge");
        @(negedge clk);
        rst = 1'b0;
        tick();
        exp_h = 9'd1;
        chk("resume_hcnt",  int'(vif_a._HCNT),  int'(exp_h));
        chk("resume_vcnt",  int'(vif_a._VCNT),  0);
        chk("resume_hsync", int'(vif_a._HSYNC), 1);
        vif_a._CE = 1'b0;

        // Small raster checkpoints (B was cleared by the reset above).
        chk("b_start_hcnt", int'(vif_b._HCNT), 0);
        chk("b_start_vcnt", int'(vif_b._VCNT), 0);
        for (int e = 0; e < 18; e++) begin
            vif_b._CE = vecs[e].ce;
            nfr = 0;
            for (int k = 0; k < vecs[e].adv; k++) begin
                tick();
                if (vif_b._FRAME) nfr++;
`ifdef VIDEO_SYNC_GEN_CSYNC_EN
                chk($sformatf("v%0d_csync", e), int'(vif_b._CSYNC),
                    int'(vif_b._HSYNC & vif_b._VSYNC));
`endif
            end
            chk($sformatf("v%0d_hcnt", e),   int'(vif_b._HCNT),   vecs[e].h);
            chk($sformatf("v%0d_vcnt", e),   int'(vif_b._VCNT),   vecs[e].v);
            chk($sformatf("v%0d_hsync", e),  int'(vif_b._HSYNC),  int'(vecs[e].hs));
            chk($sformatf("v%0d_vsync", e),  int'(vif_b._VSYNC),  int'(vecs[e].vs));
            chk($sformatf("v%0d_hblank", e), int'(vif_b._HBLANK), int'(vecs[e].hb));
            chk($sformatf("v%0d_vblank", e), int'(vif_b._VBLANK), int'(vecs[e].vb));
            chk($sformatf("v%0d_frame", e),  int'(vif_b._FRAME),  int'(vecs[e].fr));
            chk($sformatf("v%0d_nframes", e), nfr, vecs[e].nfr);
        end
        vif_b._CE = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_sync_gen.md
# video_sync_gen

Raster timing generator for the Kangaroo video path. It sits directly downstream of the 74LS163 pixel prescaler, and its _CE input is that counter's ripple-carry (RCO). It holds cascaded horizontal and vertical position counters, decodes them into the sync and blanking outputs, and emits a one-cycle frame strobe for the sprite and playfield logic.

## Interface
- CW, 9: width of each position counter
- H_TOTAL, 384: pixel periods per line (counter wraps at H_TOTAL-1)
- H_ACTIVE, 256: visible pixels per line, 0..H_ACTIVE-1
- H_SYNC_START, 296: first pixel period with _HSYNC asserted
- H_SYNC_END, 328: first pixel period after _HSYNC deasserts
- V_TOTAL, 264: lines per frame
- V_ACTIVE, 240: visible lines
- V_SYNC_START, 244: first line with _VSYNC asserted
- V_SYNC_END, 247: first line after _VSYNC deasserts
- _CLK  input  1  system clock; all state changes on the rising edge
- _CLR  input  1  reset; asynchronous, active-high
- _CE  input  1  pixel advance enable (prescaler RCO); active-high
- _HCNT  output  CW  current horizontal position
- _VCNT  output  CW  current vertical position
- _HSYNC  output  1  horizontal sync, active-low
- _VSYNC  output  1  vertical sync, active-low
- _HBLANK  output  1  high when _HCNT >= H_ACTIVE
- _VBLANK  output  1  high when _VCNT >= V_ACTIVE
- _FRAME  output  1  one-_CLK-cycle strobe at frame start

## Operation
- **Reset.** While _CLR is high: _HCNT=0, _VCNT=0, _HSYNC=1, _VSYNC=1, _HBLANK=0, _VBLANK=0, _FRAME=0.
- **Hold.** With _CE=0, every output holds, except _FRAME, which is 0.
- **Horizontal advance.** With _CE=1 at an edge: if _HCNT = H_TOTAL-1, _HCNT goes to 0; otherwise _HCNT increments by 1.
- **Vertical advance.** _VCNT changes only on an edge where _CE=1 and _HCNT = H_TOTAL-1. If _VCNT = V_TOTAL-1 it goes to 0; otherwise it increments.
- **Decode.** The decode outputs are registered from the next-count values, so they always match the counter values presented in the same cycle:
  - _HSYNC = 0 iff H_SYNC_START <= _HCNT < H_SYNC_END.
  - _VSYNC = 0 iff V_SYNC_START <= _VCNT < V_SYNC_END.
  - The blanking outputs follow the thresholds given under Interface.
- **Frame strobe.** _FRAME=1 for exactly the one cycle after the edge on which both counters wrap to (0,0). The strobe never lasts longer than one cycle, even if _CE stays high.
- **Arithmetic.** Increments are unsigned, modulo the TOTAL parameter. Counts above TOTAL-1 are unreachable. The comparators are unsigned and CW bits wide.
- **Parameter legality** (checked by elaboration-time assertion):
  - H_ACTIVE < H_SYNC_START < H_SYNC_END <= H_TOTAL <= 2**CW
  - V_ACTIVE < V_SYNC_START < V_SYNC_END <= V_TOTAL <= 2**CW
- **Reset mid-frame.** Asserting _CLR forces the reset values immediately, with no wait for an edge. Counting resumes from (0,0) on the first edge after release that has _CE=1.
- **Reset wins.** _CE=1 coincident with _CLR has no effect.

## Timing
- Latency from counter change to decode change: 0 cycles. Counters and decode outputs update on the same edge.
- _CE is sampled on the rising edge of _CLK and must be synchronous to _CLK.
- Line period: H_TOTAL _CE pulses.
- Frame period: H_TOTAL*V_TOTAL _CE pulses.
- With _CE tied high: _FRAME period is 101376 _CLK cycles at the default parameters.
- _CLR release must meet recovery time to _CLK. The bench releases it half a cycle away from the rising edge.

## Configuration
- Macro: VIDEO_SYNC_GEN_CSYNC_EN.
- **Defined:**
  - Adds output _CSYNC (1 bit, active-low), registered, equal to _HSYNC AND _VSYNC.
  - Its reset value is 1.
  - It has the same zero-latency alignment as the other decode outputs.
- **Undefined:** the _CSYNC port and its logic are absent. All other behaviour is identical.

## Structure
- **Shared package.** kangaroo_video_pkg holds:
  - the default timing constants (H_/V_ TOTAL, ACTIVE, SYNC_START, SYNC_END);
  - the CW default;
  - typedef pos_t as logic [CW-1:0].
- **Sub-module.** One sub-module, video_mod_counter (parameters W and MOD; ports _CLK, _CLR, _CE, count, _TC), instantiated twice:
  - The horizontal instance's _TC gates the vertical instance's _CE.
  - _TC = _CE AND (count = MOD-1).

## Test plan
- **Reset values.** Assert _CLR for 3 cycles with _CE=1 -> all outputs stay at their reset values, and _HCNT, _VCNT stay 0.
- **Hold.** Release _CLR, hold _CE=0 for 20 cycles -> _HCNT=0, _VCNT=0, _FRAME=0 throughout.
- **Line wrap and horizontal decode.** _CE=1 for 384 cycles -> _HCNT counts 0..383 then returns to 0, and _VCNT goes to 1 on the same edge. _HBLANK first rises at _HCNT=256. _HSYNC is low for _HCNT 296..327 (32 cycles).
- **Frame wrap and vertical decode.** _CE=1 for 101376 cycles -> _VSYNC is low for lines 244..246 only. _VBLANK is high for lines 240..263. _FRAME is high for exactly 1 cycle as (0,0) is re-entered.
- **Reset mid-line.** Assert _CLR asynchronously at _HCNT=100, _VCNT=50 -> outputs go to reset values before the next edge. After release, the first _CE edge gives _HCNT=1.
- **Macro defined.** Build with VIDEO_SYNC_GEN_CSYNC_EN -> _CSYNC=0 exactly when _HSYNC=0 or _VSYNC=0, and 1 after reset.
